// File: rtl/gdm_pkg.sv
// Shared definitions for the GDM arbiter slice.
// Contents: default bus widths, FSM state encoding and requester owner IDs.
package gdm_pkg;

    localparam int GDM_ADDR_W = 32;
    localparam int GDM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_XFER  = 2'b01,
        MEM_XFER = 2'b10
    } gdm_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } gdm_owner_e;

endpackage

// File: rtl/gdm_arb_prio.sv
// Grant selection for the GDM arbiter plus the IF starvation counter.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   if_req, mem_req     current requests from the two requesters
//   idle                arbiter is free to grant this cycle
//   grant               a winner is chosen this cycle (only while idle)
//   winner              owner ID of the winner, valid when grant=1
module gdm_arb_prio
    import gdm_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       if_req,
    input  logic       mem_req,
    input  logic       idle,
    output logic       grant,
    output gdm_owner_e winner
);

    logic [3:0] starve_cnt;
    logic       forced_if;

    // IF has waited through STARVE_MAX MEM grants: it takes the next slot.
    assign forced_if = if_req && (starve_cnt >= 4'(STARVE_MAX));

    always_comb begin
        grant  = 1'b0;
        winner = OWN_IF;
        if (idle) begin
            if (mem_req && !forced_if) begin
                grant  = 1'b1;
                winner = OWN_MEM;
            end else if (if_req) begin
                grant  = 1'b1;
                winner = OWN_IF;
            end
        end
    end

    // Counts MEM grants that passed over a waiting IF; saturates at 15.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (winner == OWN_IF) begin
                starve_cnt <= 4'd0;
            end else if (if_req && (starve_cnt != 4'd15)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/gdm_arbiter.sv
// Arbiter sharing the single GDM memory port between instruction fetch (IF)
// and the memory-access stage (MEM). MEM has priority; a starvation guard
// forces an IF grant after STARVE_MAX consecutive MEM grants over a waiting IF.
//
// Handshake: a requester raises *_req and holds it (and its address/data)
// while arb_*_stall is 1. The stall drops in the cycle GDM completes the
// owner's access (gdm_ready=1 in the XFER state); the next cycle carries a
// one-cycle *_valid pulse with the read data. Inputs are latched at grant and
// ignored until completion; a dropped request still gets its result pulse.
//
// Ports:
//   clock, reset                       clock, asynchronous active-high reset
//   if_req/if_addr                     IF fetch request
//   if_valid/if_rdata/arb_if_stall     IF result pulse, data and stall
//   mem_req/mem_we/mem_addr/mem_wdata  MEM load/store request
//   mem_valid/mem_rdata/arb_mem_stall  MEM completion pulse, data and stall
//   gdm_en/gdm_we/gdm_addr/gdm_wdata   registered GDM access outputs
//   gdm_rdata/gdm_ready                GDM read data and completion
//   arb_timeout                        sticky: a transfer was aborted
//   state_dbg                          current FSM state (debug)
module gdm_arbiter
    import gdm_pkg::*;
#(
    parameter int ADDR_W     = GDM_ADDR_W,
    parameter int DATA_W     = GDM_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              arb_if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              arb_mem_stall,
    output logic              gdm_en,
    output logic              gdm_we,
    output logic [ADDR_W-1:0] gdm_addr,
    output logic [DATA_W-1:0] gdm_wdata,
    input  logic [DATA_W-1:0] gdm_rdata,
    input  logic              gdm_ready,
    output logic              arb_timeout,
    output logic [1:0]        state_dbg
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    gdm_state_e        state, state_nx;
    logic              grant;
    gdm_owner_e        winner;
    logic [TW-1:0]     tcnt;
    logic              tmo_hit;
    logic              xfer_end;
    logic [DATA_W-1:0] xfer_data;

    gdm_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clock  (clock),
        .reset  (reset),
        .if_req (if_req),
        .mem_req(mem_req),
        .idle   (state == IDLE),
        .grant  (grant),
        .winner (winner)
    );

    // tcnt counts completed wait cycles; the last allowed one aborts.
    assign tmo_hit   = (TIMEOUT != 0) && (tcnt == T_LAST);
    assign xfer_data = gdm_ready ? gdm_rdata : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        xfer_end = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = (winner == OWN_MEM) ? MEM_XFER : IF_XFER;
                end
            end
            IF_XFER, MEM_XFER: begin
                if (gdm_ready || tmo_hit) begin
                    xfer_end = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gdm_en      <= 1'b0;
            gdm_we      <= 1'b0;
            gdm_addr    <= '0;
            gdm_wdata   <= '0;
            if_valid    <= 1'b0;
            if_rdata    <= '0;
            mem_valid   <= 1'b0;
            mem_rdata   <= '0;
            arb_timeout <= 1'b0;
            tcnt        <= '0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if (state == IDLE) begin
                if (grant) begin
                    gdm_en <= 1'b1;
                    tcnt   <= '0;
                    if (winner == OWN_MEM) begin
                        gdm_we    <= mem_we;
                        gdm_addr  <= mem_addr;
                        gdm_wdata <= mem_wdata;
                    end else begin
                        gdm_we    <= 1'b0;
                        gdm_addr  <= if_addr;
                        gdm_wdata <= '0;
                    end
                end
            end else if (xfer_end) begin
                gdm_en <= 1'b0;
                gdm_we <= 1'b0;
                if (state == MEM_XFER) begin
                    mem_valid <= 1'b1;
                    mem_rdata <= xfer_data;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= xfer_data;
                end
                // Ended without gdm_ready: this was a timeout abort.
                if (!gdm_ready) begin
                    arb_timeout <= 1'b1;
                end
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    assign arb_if_stall  = if_req && !((state == IF_XFER) && gdm_ready);
    assign arb_mem_stall = mem_req && !((state == MEM_XFER) && gdm_ready);
    assign state_dbg     = state;

endmodule
